// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_unit
// Brief    : RAW hazard detection, stall/flush control and EX operand
//            forwarding for a 5-stage in-order pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit #(
    parameter int FORWARDING = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic        ex_redirect,
    output logic        pc_write_enable,
    output logic        if_id_write_enable,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [1:0]  forward_a_select,
    output logic [1:0]  forward_b_select,
    output logic [31:0] stall_cycles
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
    } sb_entry_t;

    sb_entry_t   r_ex;
    sb_entry_t   r_mem;
    sb_entry_t   r_wb;
    sb_entry_t   w_id_entry;
    logic [31:0] r_stall_cycles;
    logic        w_stall;
    logic        w_stall_applied;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;
    logic        w_unused_fields;

    // x0 is hard-wired zero, so a write to it is never a producer.
    function automatic logic f_match(input sb_entry_t e, input logic [4:0] src,
                                     input logic uses);
        return e.valid && e.reg_write && (e.rd != 5'd0) && uses && (e.rd == src);
    endfunction

    function automatic logic [1:0] f_fwd_sel(input sb_entry_t mem_e, input sb_entry_t wb_e,
                                             input logic [4:0] src, input logic uses);
        if (f_match(mem_e, src, uses)) begin
            return 2'd1;
        end else if (f_match(wb_e, src, uses)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    generate
        if (FORWARDING != 0) begin : g_forwarding
            // Only a load in EX cannot be bypassed; everything else forwards.
            assign w_stall = id_valid && r_ex.is_load &&
                             (f_match(r_ex, id_rs1, id_uses_rs1) ||
                              f_match(r_ex, id_rs2, id_uses_rs2));
            assign w_fwd_a = f_fwd_sel(r_mem, r_wb, r_ex.rs1, r_ex.uses_rs1);
            assign w_fwd_b = f_fwd_sel(r_mem, r_wb, r_ex.rs2, r_ex.uses_rs2);
        end else begin : g_stall_only
            assign w_stall = id_valid &&
                             (f_match(r_ex,  id_rs1, id_uses_rs1) ||
                              f_match(r_ex,  id_rs2, id_uses_rs2) ||
                              f_match(r_mem, id_rs1, id_uses_rs1) ||
                              f_match(r_mem, id_rs2, id_uses_rs2) ||
                              f_match(r_wb,  id_rs1, id_uses_rs1) ||
                              f_match(r_wb,  id_rs2, id_uses_rs2));
            assign w_fwd_a = 2'd0;
            assign w_fwd_b = 2'd0;
        end
    endgenerate

    assign w_stall_applied = w_stall && !ex_redirect;

    always_comb begin
        pc_write_enable    = 1'b1;
        if_id_write_enable = 1'b1;
        if_id_flush        = 1'b0;
        id_ex_bubble       = 1'b0;
        forward_a_select   = w_fwd_a;
        forward_b_select   = w_fwd_b;
        if (!reset) begin
            pc_write_enable    = 1'b0;
            if_id_write_enable = 1'b0;
            id_ex_bubble       = 1'b1;
            forward_a_select   = 2'd0;
            forward_b_select   = 2'd0;
        end else if (ex_redirect) begin
            if_id_flush        = 1'b1;
            id_ex_bubble       = 1'b1;
        end else if (w_stall) begin
            pc_write_enable    = 1'b0;
            if_id_write_enable = 1'b0;
            id_ex_bubble       = 1'b1;
        end
    end

    always_comb begin
        w_id_entry          = '0;
        w_id_entry.valid    = id_valid && !id_ex_bubble;
        w_id_entry.rd       = id_rd;
        w_id_entry.reg_write= id_reg_write;
        w_id_entry.is_load  = id_is_load;
        w_id_entry.rs1      = id_rs1;
        w_id_entry.rs2      = id_rs2;
        w_id_entry.uses_rs1 = id_uses_rs1;
        w_id_entry.uses_rs2 = id_uses_rs2;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ex           <= '0;
            r_mem          <= '0;
            r_wb           <= '0;
            r_stall_cycles <= 32'd0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_id_entry;
            if (w_stall_applied) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign w_unused_fields = ^{r_ex, r_mem, r_wb};

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_unit
// Brief    : Directed scenarios plus random stimulus for both FORWARDING
//            settings, checked against an instruction-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load, ex_redirect;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic [1:0]  o_pc, o_ifid_we, o_flush, o_bub;
    logic [1:0]  o_fa [2];
    logic [1:0]  o_fb [2];
    logic [31:0] o_cnt [2];

    pipeline_hazard_unit #(.FORWARDING(1)) dut_f (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .pc_write_enable(o_pc[0]), .if_id_write_enable(o_ifid_we[0]),
        .if_id_flush(o_flush[0]), .id_ex_bubble(o_bub[0]), .forward_a_select(o_fa[0]),
        .forward_b_select(o_fb[0]), .stall_cycles(o_cnt[0])
    );

    pipeline_hazard_unit #(.FORWARDING(0)) dut_s (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .pc_write_enable(o_pc[1]), .if_id_write_enable(o_ifid_we[1]),
        .if_id_flush(o_flush[1]), .id_ex_bubble(o_bub[1]), .forward_a_select(o_fa[1]),
        .forward_b_select(o_fb[1]), .stall_cycles(o_cnt[1])
    );

    always #5 clock = ~clock;

    // hist[k][d]: instruction that entered the pipe d+1 edges ago (0=EX,1=MEM,2=WB)
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
    } ent_t;

    ent_t        hist [2][3];
    int unsigned cnt [2];
    bit          e_stall [2];
    bit          e_bub [2];
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] c0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads(input ent_t e, input bit [4:0] src, input bit uses);
        return e.valid && e.wr && e.rd != 0 && uses && e.rd == src;
    endfunction

    function automatic bit model_stall(input int k);
        if (!id_valid) return 1'b0;
        // forwarding only loses to a load one instruction ahead; stall-only waits out 3
        for (int d = 0; d < ((k == 0) ? 1 : 3); d++) begin
            if ((k == 1 || hist[k][d].ld) &&
                (reads(hist[k][d], id_rs1, id_uses_rs1) || reads(hist[k][d], id_rs2, id_uses_rs2)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit [1:0] model_sel(input int k, input bit [4:0] src, input bit uses);
        if (k == 1) return 2'd0;
        for (int d = 1; d <= 2; d++)
            if (reads(hist[k][d], src, uses)) return d[1:0];
        return 2'd0;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0;
            for (int d = 0; d < 3; d++) hist[k][d] = '{default: 0};
        end
    endtask

    task automatic check_outputs();
        bit [3:0] ctl;
        bit [1:0] sa, sb;
        for (int k = 0; k < 2; k++) begin
            e_stall[k] = model_stall(k);
            sa = 0;
            sb = 0;
            if (!reset)             ctl = 4'b0001;
            else if (ex_redirect)   ctl = 4'b1111;
            else if (e_stall[k])    ctl = 4'b0001;
            else                    ctl = 4'b1100;
            if (reset) begin
                sa = model_sel(k, hist[k][0].rs1, hist[k][0].u1);
                sb = model_sel(k, hist[k][0].rs2, hist[k][0].u2);
            end
            e_bub[k] = ctl[0];
            check($sformatf("pc_we[%0d]", k),   32'(o_pc[k]),      32'(ctl[3]));
            check($sformatf("ifid_we[%0d]", k), 32'(o_ifid_we[k]), 32'(ctl[2]));
            check($sformatf("flush[%0d]", k),   32'(o_flush[k]),   32'(ctl[1]));
            check($sformatf("bubble[%0d]", k),  32'(o_bub[k]),     32'(ctl[0]));
            check($sformatf("fwd_a[%0d]", k),   32'(o_fa[k]),      32'(sa));
            check($sformatf("fwd_b[%0d]", k),   32'(o_fb[k]),      32'(sb));
        end
    endtask

    // Entered at the falling edge with inputs already driven.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clock);
        if (!reset) begin
            clear_model();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (e_stall[k] && !ex_redirect) cnt[k]++;
                hist[k][2] = hist[k][1];
                hist[k][1] = hist[k][0];
                hist[k][0] = '{valid: id_valid && !e_bub[k], rd: id_rd, wr: id_reg_write,
                               ld: id_is_load, rs1: id_rs1, rs2: id_rs2,
                               u1: id_uses_rs1, u2: id_uses_rs2};
            end
        end
        #1;
        check("stall_cycles[0]", o_cnt[0], cnt[0]);
        check("stall_cycles[1]", o_cnt[1], cnt[1]);
        @(negedge clock);
    endtask

    task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit u1, input bit u2, input bit [4:0] rd,
                          input bit wr, input bit ld, input bit redir);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_is_load = ld; ex_redirect = redir;
    endtask

    initial begin
        clear_model();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        cycle();
        cycle();
        reset = 1'b1;

        // load x5 followed by add x6,x5,x5
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); cycle();
        set_id(1, 5, 5, 1, 1, 6, 1, 0, 0); #1 check("lu_stall_pc", 32'(o_pc[0]), 0);
        cycle();
        check("lu_count", o_cnt[0], 1);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("lu_fwd_a", 32'(o_fa[0]), 2);
        check("lu_fwd_b", 32'(o_fb[0]), 2);
        cycle();

        // add x7 ; sub x8,x7,x1
        set_id(1, 1, 2, 1, 1, 7, 1, 0, 0); cycle();
        set_id(1, 7, 1, 1, 1, 8, 1, 0, 0); #1 check("alu_no_stall", 32'(o_pc[0]), 1);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 check("alu_fwd_a", 32'(o_fa[0]), 1);
        cycle();

        // x0 writer never hazards; x3 in MEM and WB picks MEM
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 0); cycle();
        set_id(1, 0, 0, 1, 1, 9, 1, 0, 0); #1 check("x0_no_stall", 32'(o_pc[0]), 1);
        cycle();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); cycle();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); cycle();
        set_id(1, 3, 0, 1, 0, 9, 1, 0, 0); cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 check("prio_fwd_a", 32'(o_fa[0]), 1);
        cycle();

        // redirect in the same cycle as a load-use
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); cycle();
        c0 = o_cnt[0];
        set_id(1, 5, 5, 1, 1, 6, 1, 0, 1); #1;
        check("rd_flush", 32'(o_flush[0]), 1);
        check("rd_pc", 32'(o_pc[0]), 1);
        cycle();
        check("rd_count_held", o_cnt[0], c0);

        // stall-only: add x4 then reader of x4
        reset = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        reset = 1'b1;
        set_id(1, 0, 0, 0, 0, 4, 1, 0, 0); cycle();
        set_id(1, 4, 0, 1, 0, 10, 1, 0, 0);
        repeat (4) cycle();
        check("nofwd_count", o_cnt[1], 3);

        // reset asserted mid-stall takes effect without a clock edge
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); cycle();
        set_id(1, 5, 0, 1, 0, 6, 1, 0, 0);
        #2 reset = 1'b0;
        clear_model();
        #1 check_outputs();
        check("async_count", o_cnt[0], 0);
        @(negedge clock);
        reset = 1'b1;

        // counter wrap
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); cycle();
        force dut_f.r_stall_cycles = 32'hFFFF_FFFF;
        #1 release dut_f.r_stall_cycles;
        cnt[0] = 32'hFFFF_FFFF;
        set_id(1, 5, 0, 1, 0, 6, 1, 0, 0); cycle();
        check("wrap_count", o_cnt[0], 0);

        repeat (400) begin
            reset = ($urandom_range(0, 39) != 0);
            set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 Parameter: FORWARDING, default 1, meaning 1 = EX-operand forwarding enabled and 0 = resolve every RAW hazard by stalling.
REQ-002 Port: clock  in  1  the single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: id_valid  in  1  the ID stage holds a valid instruction.
REQ-005 Port: id_rs1, id_rs2  in  5 each  ID source register addresses.
REQ-006 Port: id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads that source register.
REQ-007 Port: id_rd  in  5  ID destination register.
REQ-008 Port: id_reg_write  in  1  the ID instruction writes id_rd.
REQ-009 Port: id_is_load  in  1  the ID instruction is a load.
REQ-010 Port: ex_redirect  in  1  the EX instruction resolved a taken branch or jump this cycle.
REQ-011 Port: pc_write_enable  out  1  PC register update enable.
REQ-012 Port: if_id_write_enable  out  1  IF/ID register update enable.
REQ-013 Port: if_id_flush  out  1  replace the IF/ID contents with a bubble.
REQ-014 Port: id_ex_bubble  out  1  load a bubble into ID/EX instead of the ID instruction.
REQ-015 Port: forward_a_select, forward_b_select  out  2 each  EX operand source: 0 = regfile, 1 = EX/MEM ALU result, 2 = MEM/WB writeback data.
REQ-016 Port: stall_cycles  out  32  count of stall cycles.

Function
REQ-017 The unit SHALL keep a scoreboard for each of EX, MEM and WB holding valid, rd, reg_write, is_load, rs1, rs2, uses_rs1 and uses_rs2.
REQ-018 On each clock edge the scoreboard SHALL shift as follows: WB takes MEM, MEM takes EX, and EX takes the ID fields with valid = id_valid && !id_ex_bubble, otherwise an invalid entry.
REQ-019 A stage SHALL match a source register only when the stage is valid, its reg_write is 1, its rd != 0, the ID instruction uses that source, and rd equals that source; register x0 SHALL never cause a hazard.
REQ-020 With FORWARDING=1, stall SHALL equal id_valid && the EX entry is a load && the EX entry matches id_rs1 or id_rs2, giving exactly one load-use bubble.
REQ-021 With FORWARDING=0, stall SHALL equal id_valid && any of the EX, MEM or WB entries matches id_rs1 or id_rs2.
REQ-022 With FORWARDING=0, both forward selects SHALL be held at 0.
REQ-023 With FORWARDING=1, forward_a_select SHALL be 1 if the MEM entry matches the EX entry's rs1, else 2 if the WB entry matches it, else 0.
REQ-024 In REQ-023 the match SHALL use the EX entry's uses_rs1, and the MEM entry SHALL take priority over the WB entry.
REQ-025 forward_b_select SHALL be derived the same way as forward_a_select, using rs2 and uses_rs2.
REQ-026 During a stall (stall && !ex_redirect) the outputs SHALL be pc_write_enable=0, if_id_write_enable=0, id_ex_bubble=1 and if_id_flush=0.
REQ-027 When ex_redirect=1 the outputs SHALL be pc_write_enable=1, if_id_write_enable=1, if_id_flush=1 and id_ex_bubble=1, giving a 2-cycle redirect penalty.
REQ-028 ex_redirect SHALL take priority over stall in the same cycle; no stall is applied and no stall is counted.
REQ-029 Otherwise the outputs SHALL be pc_write_enable=1, if_id_write_enable=1, if_id_flush=0 and id_ex_bubble=0.
REQ-030 All control and forward outputs SHALL be combinational from the scoreboard and the current inputs, with zero latency.
REQ-031 stall_cycles SHALL increment by 1 on each edge where stall && !ex_redirect, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 id_valid=0 SHALL never stall.

Reset
REQ-033 While reset=0, the scoreboard SHALL be cleared to all-invalid and stall_cycles SHALL be 0.
REQ-034 While reset=0, the outputs SHALL be pc_write_enable=0, if_id_write_enable=0, if_id_flush=0, id_ex_bubble=1 and forward selects 0, independent of the clock.
REQ-035 Reset asserted mid-stall or mid-redirect SHALL abort it immediately.
REQ-036 On the first edge after release the unit SHALL behave per REQ-029.

Verification
REQ-037 Scenario, load-use (FORWARDING=1): EX load x5, then ID add x6,x5,x5 -> stall for 1 cycle, stall_cycles=1, and on the next cycle forward_a_select=2 and forward_b_select=2.
REQ-038 Scenario, ALU back-to-back (FORWARDING=1): add x7 followed by sub x8,x7,x1 -> no stall, and forward_a_select=1 while sub is in EX.
REQ-039 Scenario, x0 and priority (FORWARDING=1): writes to x0 -> never forward or stall; x3 written in both MEM and WB -> select=1.
REQ-040 Scenario, redirect+stall (FORWARDING=1): ex_redirect=1 in the same cycle as a load-use -> if_id_flush=1, id_ex_bubble=1, pc_write_enable=1 and stall_cycles unchanged.
REQ-041 Scenario, FORWARDING=0: add x4 followed by a reader of x4 -> 3 stall cycles, selects always 0, and stall_cycles=3.
REQ-042 Scenario, reset and wrap: assert reset mid-stall -> outputs take the reset values asynchronously; preload 0xFFFFFFFF and stall once -> stall_cycles=0.
